// File: rtl/etapa_fetch.sv
// -----------------------------------------------------------------------------
// etapa_fetch: instruction-fetch stage feeding the IF/ID pipeline register.
//
// Owns the PC, selects the next PC (sequential or branch redirect), drives a
// variable-latency instruction-memory req/ready handshake and registers each
// fetched instruction into IF/ID. A one-entry skid buffer absorbs the word that
// completes while decode is stalled, so an open request never has to be
// withdrawn.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   mem_req         request to instruction memory (decoded from state)
//   mem_addr        fetch address (the PC register)
//   mem_ready       memory completes the request this cycle
//   mem_rdata       fetched instruction
//   stall           decode cannot accept; IF/ID holds
//   branch_taken    redirect to branch_target, flushing IF/ID and skid
//   branch_target   redirect address
//   if_id_instr     registered instruction to decode
//   if_id_pc_next   registered PC+PC_INC of that instruction
//   if_id_valid     IF/ID holds a real instruction
//   pc_actual       current PC register (debug)
// -----------------------------------------------------------------------------
module etapa_fetch #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int PC_INC   = 4,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc_next,
    output logic              if_id_valid,
    output logic [ADDR_W-1:0] pc_actual
);

    typedef enum logic [1:0] {
        ARRANQUE   = 2'd0,
        PIDE       = 2'd1,
        DESCARTA   = 2'd2,
        ESPERA_BUF = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PC_INC_V   = ADDR_W'(PC_INC);
    localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   if_id_instr_q, if_id_instr_d;
    logic [ADDR_W-1:0]   if_id_pc_next_q, if_id_pc_next_d;
    logic                if_id_valid_q, if_id_valid_d;
    // Skid occupancy is implied by ESPERA_BUF, so no separate valid flag.
    logic [DATA_W-1:0]   skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0]   skid_pc_next_q, skid_pc_next_d;
    logic [ADDR_W-1:0]   pend_target_q, pend_target_d;

    logic                mem_req_s;
    logic                transfer_s;
    logic [ADDR_W-1:0]   pc_inc_s;

    // Request is a pure decode of the state register; the address is the PC.
    assign mem_req_s  = (state_q == PIDE) || (state_q == DESCARTA);
    assign transfer_s = mem_req_s && mem_ready;
    // Modulo 2^ADDR_W: the sum simply wraps.
    assign pc_inc_s   = pc_q + PC_INC_V;

    assign mem_req       = mem_req_s;
    assign mem_addr      = pc_q;
    assign pc_actual     = pc_q;
    assign if_id_instr   = if_id_instr_q;
    assign if_id_pc_next = if_id_pc_next_q;
    assign if_id_valid   = if_id_valid_q;

    // Next-state, next-PC, IF/ID and skid selection.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        if_id_instr_d   = if_id_instr_q;
        if_id_pc_next_d = if_id_pc_next_q;
        skid_instr_d    = skid_instr_q;
        skid_pc_next_d  = skid_pc_next_q;
        pend_target_d   = pend_target_q;
        // Decode consumes IF/ID every unstalled cycle; a load below overrides
        // this bubble.
        if (!stall) begin
            if_id_valid_d = 1'b0;
        end else begin
            if_id_valid_d = if_id_valid_q;
        end

        case (state_q)
            ARRANQUE: begin
                state_d = PIDE;
                if (branch_taken) begin
                    pc_d = branch_target;
                end else begin
                    pc_d = pc_q;
                end
            end

            PIDE: begin
                if (transfer_s) begin
                    if (branch_taken) begin
                        // Word belongs to the wrong path: drop it.
                        pc_d           = branch_target;
                        if_id_valid_d  = 1'b0;
                        skid_instr_d   = '0;
                        skid_pc_next_d = '0;
                    end else if (!stall || !if_id_valid_q) begin
                        if_id_instr_d   = mem_rdata;
                        if_id_pc_next_d = pc_inc_s;
                        if_id_valid_d   = 1'b1;
                        pc_d            = pc_inc_s;
                    end else begin
                        // IF/ID is full and held: park the word in the skid.
                        skid_instr_d   = mem_rdata;
                        skid_pc_next_d = pc_inc_s;
                        pc_d           = pc_inc_s;
                        state_d        = ESPERA_BUF;
                    end
                end else if (branch_taken) begin
                    // Request is still open and its address must stay put;
                    // remember the target and let the old word drain.
                    pend_target_d = branch_target;
                    if_id_valid_d = 1'b0;
                    state_d       = DESCARTA;
                end else begin
                    state_d = PIDE;
                end
            end

            DESCARTA: begin
                if_id_valid_d = 1'b0;
                if (branch_taken) begin
                    pend_target_d = branch_target;
                end else begin
                    pend_target_d = pend_target_q;
                end
                if (transfer_s) begin
                    // A redirect arriving with the transfer is the newest one.
                    if (branch_taken) begin
                        pc_d = branch_target;
                    end else begin
                        pc_d = pend_target_q;
                    end
                    state_d = PIDE;
                end else begin
                    state_d = DESCARTA;
                end
            end

            ESPERA_BUF: begin
                if (branch_taken) begin
                    if_id_valid_d  = 1'b0;
                    skid_instr_d   = '0;
                    skid_pc_next_d = '0;
                    pc_d           = branch_target;
                    state_d        = PIDE;
                end else if (!stall) begin
                    if_id_instr_d   = skid_instr_q;
                    if_id_pc_next_d = skid_pc_next_q;
                    if_id_valid_d   = 1'b1;
                    state_d         = PIDE;
                end else begin
                    state_d = ESPERA_BUF;
                end
            end

            default: begin
                state_d       = ARRANQUE;
                pc_d          = RESET_PC_V;
                if_id_valid_d = 1'b0;
            end
        endcase
    end

    // State, PC, IF/ID, skid and pending-target registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ARRANQUE;
            pc_q            <= RESET_PC_V;
            if_id_instr_q   <= '0;
            if_id_pc_next_q <= '0;
            if_id_valid_q   <= 1'b0;
            skid_instr_q    <= '0;
            skid_pc_next_q  <= '0;
            pend_target_q   <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            if_id_instr_q   <= if_id_instr_d;
            if_id_pc_next_q <= if_id_pc_next_d;
            if_id_valid_q   <= if_id_valid_d;
            skid_instr_q    <= skid_instr_d;
            skid_pc_next_q  <= skid_pc_next_d;
            pend_target_q   <= pend_target_d;
        end
    end

endmodule

// File: doc/etapa_fetch.md
Name: etapa_fetch

Overview:
- Instruction-fetch stage directly upstream of the decode/execute datapath.
- Owns the PC and the next-PC selection (sequential or branch target).
- Drives a variable-latency instruction-memory req/ready handshake.
- Registers each fetched instruction into the IF/ID pipeline register that feeds control-unit and register-bank decode; includes a one-entry skid buffer so decode stalls never violate the memory handshake.

Parameters:
- ADDR_W, 8, PC/instruction-address width.
- DATA_W, 32, instruction width.
- PC_INC, 4, sequential PC increment.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  instruction-memory request.
- mem_addr  out  ADDR_W  fetch address; equals the PC register.
- mem_ready  in  1  memory completes the request this cycle; mem_rdata valid.
- mem_rdata  in  DATA_W  fetched instruction.
- stall  in  1  decode cannot accept; IF/ID register holds.
- branch_taken  in  1  redirect: flush IF/ID and skid, fetch from branch_target.
- branch_target  in  ADDR_W  redirect address.
- if_id_instr  out  DATA_W  registered instruction to decode.
- if_id_pc_next  out  ADDR_W  registered PC+PC_INC of that instruction.
- if_id_valid  out  1  IF/ID contents are a real instruction.
- pc_actual  out  ADDR_W  current PC register (debug).

Behaviour:
- Reset, asynchronous on rst_n=0:
  - pc=RESET_PC; state=ARRANQUE.
  - if_id_instr=0, if_id_pc_next=0, if_id_valid=0.
  - skid empty; pend_target=0; mem_req=0.
  - Reset mid-transfer abandons the request silently.
- Handshake:
  - A transfer occurs when mem_req=1 and mem_ready=1 in the same cycle.
  - Once raised, mem_req stays 1 and mem_addr stays stable until the transfer.
  - mem_req is decoded from state only: 1 in PIDE and DESCARTA, 0 otherwise.
- PC arithmetic: pc+PC_INC is modulo 2^ADDR_W, so 0xFC+4 wraps to 0x00.
- IF/ID consume rule: when stall=0, decode consumes IF/ID every cycle. If no new instruction is loaded that cycle, if_id_valid<=0 (bubble).
- States:
  - ARRANQUE: unconditionally goes to PIDE after one cycle. If branch_taken is asserted in this cycle, pc<=branch_target.
  - PIDE, transfer this cycle:
    - branch_taken=1: discard rdata; pc<=branch_target; clear IF/ID valid and skid; stay PIDE.
    - else if stall=0 or if_id_valid=0: IF/ID<={rdata, pc+INC, 1}; pc<=pc+INC; stay PIDE.
    - else (stall=1, IF/ID full): skid<={rdata, pc+INC}; pc<=pc+INC; go ESPERA_BUF.
  - PIDE, no transfer:
    - branch_taken=1: pend_target<=branch_target; clear IF/ID valid; go DESCARTA.
  - DESCARTA:
    - Keeps mem_req=1 with the old address.
    - On transfer: discard rdata; pc<=pend_target; go PIDE.
    - A further branch_taken overwrites pend_target. Simultaneous with the transfer, the newer target wins.
    - IF/ID valid is held 0 throughout.
  - ESPERA_BUF:
    - mem_req=0.
    - branch_taken=1: clear IF/ID valid and skid; pc<=branch_target; go PIDE.
    - else if stall=0: IF/ID<=skid, valid=1; skid empty; go PIDE.
    - else hold.
- Priority: branch_taken > stall. A flush clears IF/ID even while stalled.
- Latency: mem_ready in cycle N → if_id_valid=1 from cycle N+1. Zero-wait memory gives 1 instruction/cycle.
- stall=1 with if_id_valid=0: IF/ID still loads (nothing to hold).

Test Plan:
- Reset release, mem_ready tied 1, RESET_PC=0x00, rdata=0x20080005 → mem_addr 0x00,0x04,0x08 on consecutive cycles. if_id_valid=1 one cycle after first transfer, with if_id_pc_next=0x04.
- mem_ready asserted 3 cycles after mem_req → mem_addr stable all 3 cycles. if_id_valid=0 during wait and 1 the cycle after ready.
- IF/ID full, stall=1 for 4 cycles, zero-wait memory → skid captures one instruction, mem_req drops. After stall falls, IF/ID shows skid contents and fetch resumes at the next sequential address. No instruction lost or duplicated.
- branch_taken, target 0x40, while a request to 0x10 is pending 2 more cycles → mem_addr stays 0x10 until ready; that data is discarded; next request uses 0x40; if_id_valid=0 throughout.
- branch_taken and stall together while skid full → skid and IF/ID cleared; next fetch at target.
- pc=0xFC, transfer → if_id_pc_next=0x00 and next mem_addr=0x00. Assert rst_n=0 mid-wait → all outputs zero immediately, without a clock edge.
